// File: rtl/gpio_spi_tx.sv
// Queues bytes written to a PIO output port and shifts each one out as a
// mode-0 SPI frame (CPOL=0, CPHA=0), MSB first, one chip-select frame per byte.
module gpio_spi_tx #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_load,
  input  logic       clr_ovf,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic       spi_cs_n,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_HOLD,
    S_GAP
  } state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          cs_n_q, cs_n_d;
  logic          ovf_q, ovf_d;

  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic          div_end;

  assign full    = (count_q == FULL_CNT);
  assign pop     = (state_q == S_IDLE) && (count_q != '0);
  // A pop in the same cycle frees a slot, so a load on a full FIFO still lands.
  assign push    = in_load && (!full || pop);
  assign drop    = in_load && full && !pop;
  assign div_end = (div_q == DIV_LAST);

  assign spi_sclk  = sclk_q;
  assign spi_mosi  = mosi_q;
  assign spi_cs_n  = cs_n_q;
  assign overflow  = ovf_q;
  assign fifo_full = full;
  assign busy      = (count_q != '0) || (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          shift_d = mem_q[rd_ptr_q];
          mosi_d  = mem_q[rd_ptr_q][7];
          cs_n_d  = 1'b0;
          bit_d   = 3'd0;
          div_d   = '0;
          state_d = S_LOW;
        end
      end
      S_LOW: begin
        if (div_end) begin
          sclk_d  = 1'b1;
          div_d   = '0;
          state_d = S_HIGH;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (div_end) begin
          sclk_d = 1'b0;
          div_d  = '0;
          // MOSI only moves on the falling edge, keeping it stable at every rise.
          if (bit_q == 3'd7) begin
            state_d = S_HOLD;
          end else begin
            shift_d = {shift_q[6:0], 1'b0};
            mosi_d  = shift_q[6];
            bit_d   = bit_q + 3'd1;
            state_d = S_LOW;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (div_end) begin
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          div_d   = '0;
          state_d = S_GAP;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_GAP: begin
        if (div_end) begin
          div_d   = '0;
          state_d = S_IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= S_IDLE;
      div_q    <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      cs_n_q   <= cs_n_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule
